// File: rtl/arithm_sched.sv
// rtl/arithm_sched.sv - round-robin two-requester scheduler for the shared multicycle arithmetic unit
module arithm_sched #(
  parameter int WIDTH      = 32,
  parameter int ADD_CYCLES = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op_a,
  input  logic [WIDTH-1:0] req0_op_b,
  input  logic [2:0]       req0_opsel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op_a,
  input  logic [WIDTH-1:0] req1_op_b,
  input  logic [2:0]       req1_opsel,
  output logic [WIDTH-1:0] alu_op_a,
  output logic [WIDTH-1:0] alu_op_b,
  output logic [2:0]       alu_opsel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  input  logic             alu_cf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ovf,
  output logic             rsp_cf,
  output logic             busy
);

  localparam int MAX_AM  = (ADD_CYCLES > MUL_CYCLES) ? ADD_CYCLES : MUL_CYCLES;
  localparam int MAX_CYC = (MAX_AM > DIV_CYCLES) ? MAX_AM : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             capture;

  function automatic logic [CNT_W-1:0] op_cycles(input logic [2:0] opsel);
    case (opsel[2:1])
      2'b01:   op_cycles = CNT_W'(MUL_CYCLES);
      2'b10:   op_cycles = CNT_W'(DIV_CYCLES);
      default: op_cycles = CNT_W'(ADD_CYCLES);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Ready is held low while rst is asserted so nothing is accepted during reset.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = ~req0_valid;
    case (state)
      IDLE: begin
        if ((req0_valid || req1_valid) && !rst) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign busy       = (state != IDLE);

  // Operand registers feed the unit directly, so they stay put across the whole multicycle op.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_a   <= '0;
      alu_op_b   <= '0;
      alu_opsel  <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp_cf     <= 1'b0;
    end else begin
      if (accept) begin
        alu_op_a   <= grant ? req1_op_a  : req0_op_a;
        alu_op_b   <= grant ? req1_op_b  : req0_op_b;
        alu_opsel  <= grant ? req1_opsel : req0_opsel;
        last_grant <= grant;
        cnt        <= op_cycles(grant ? req1_opsel : req0_opsel);
      end else if (state == EXEC) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= last_grant;
        rsp_result <= alu_result;
        rsp_ovf    <= alu_ovf;
        rsp_cf     <= alu_cf;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arithm_sched.sv
// tb/tb_arithm_sched.sv - scoreboard bench for arithm_sched with a behavioural arithmetic unit
module tb_arithm_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
  logic [2:0]  req0_opsel, req1_opsel;
  logic [31:0] alu_op_a, alu_op_b, alu_result;
  logic [2:0]  alu_opsel;
  logic        alu_ovf, alu_cf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_cf, busy;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic rsp_seen = 1'b0;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opsel;
    logic [31:0] res;
    logic        ovf;
    logic        cf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  arithm_sched #(.WIDTH(32), .ADD_CYCLES(1), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_a(req0_op_a),
    .req0_op_b(req0_op_b), .req0_opsel(req0_opsel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_a(req1_op_a),
    .req1_op_b(req1_op_b), .req1_opsel(req1_opsel),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_opsel(alu_opsel),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_cf(alu_cf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_cf(rsp_cf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic unit stand-in: unsigned mul/div, all-ones quotient on divide by zero.
  logic [63:0] prod;
  logic [32:0] sum;
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_cf     = 1'b0;
    prod       = {32'd0, alu_op_a} * {32'd0, alu_op_b};
    sum        = {1'b0, alu_op_a} + {1'b0, alu_op_b};
    case (alu_opsel)
      3'b000: begin
        alu_result = sum[31:0];
        alu_cf     = sum[32];
        alu_ovf    = (alu_op_a[31] == alu_op_b[31]) && (sum[31] != alu_op_a[31]);
      end
      3'b001: begin
        alu_result = alu_op_a - alu_op_b;
        alu_cf     = alu_op_a < alu_op_b;
        alu_ovf    = (alu_op_a[31] != alu_op_b[31]) && (alu_result[31] != alu_op_a[31]);
      end
      3'b010:  alu_result = prod[31:0];
      3'b011:  alu_result = prod[63:32];
      3'b100:  alu_result = (alu_op_b == 0) ? 32'hFFFF_FFFF : alu_op_a / alu_op_b;
      3'b101:  alu_result = (alu_op_b == 0) ? alu_op_a : alu_op_a % alu_op_b;
      default: alu_result = '0;
    endcase
  end

  // Scoreboard monitor: operand stability in EXEC, response latency, response contents.
  always @(negedge clk) begin
    if (rst) begin
      rsp_seen = 1'b0;
    end else begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc + 1;
      if (busy && !rsp_valid && sb.size() > 0) begin
        checks++;
        if (alu_op_a !== sb[0].a || alu_op_b !== sb[0].b || alu_opsel !== sb[0].opsel) begin
          errors++;
          $display("FAIL alu_stable: got a=%h b=%h sel=%b want a=%h b=%h sel=%b",
                   alu_op_a, alu_op_b, alu_opsel, sb[0].a, sb[0].b, sb[0].opsel);
        end
      end
      if (rsp_valid && !rsp_seen) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 result=%h want no response", rsp_result);
        end else if (cyc - acc_cyc != sb[0].lat) begin
          errors++;
          $display("FAIL latency: got %0d cycles want %0d", cyc - acc_cyc, sb[0].lat);
        end
      end
      rsp_seen = rsp_valid;
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (rsp_id !== e.id || rsp_result !== e.res || rsp_ovf !== e.ovf || rsp_cf !== e.cf) begin
          errors++;
          $display("FAIL rsp: got id=%b res=%h ovf=%b cf=%b want id=%b res=%h ovf=%b cf=%b",
                   rsp_id, rsp_result, rsp_ovf, rsp_cf, e.id, e.res, e.ovf, e.cf);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic push(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] opsel, input logic [31:0] res, input logic ovf,
                      input logic cf, input int lat);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.opsel = opsel; e.res = res; e.ovf = ovf; e.cf = cf; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic n, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] opsel, input logic [31:0] res, input logic ovf,
                       input logic cf, input int lat);
    int k = 0;
    push(n, a, b, opsel, res, ovf, cf, lat);
    if (n) begin
      req1_valid = 1'b1; req1_op_a = a; req1_op_b = b; req1_opsel = opsel;
    end else begin
      req0_valid = 1'b1; req0_op_a = a; req0_op_b = b; req0_opsel = opsel;
    end
    #1;
    while (!(n ? req1_ready : req0_ready) && k < 100) begin
      step();
      k++;
    end
    checks++;
    if (!(n ? req1_ready : req0_ready)) begin
      errors++;
      $display("FAIL issue_timeout: got ready=0 for req%0d want ready=1", n);
    end else begin
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL idle_timeout: got pending=%0d busy=%b want 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op_a = 32'h11; req0_op_b = 32'h22; req0_opsel = 3'b000;
    req1_op_a = 32'h33; req1_op_b = 32'h44; req1_opsel = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
          alu_op_a !== 32'd0 || alu_op_b !== 32'd0 || alu_opsel !== 3'd0) begin
        errors++;
        $display("FAIL reset_state: got rdy=%b%b rsp_valid=%b busy=%b alu=%h/%h/%b want all 0",
                 req0_ready, req1_ready, rsp_valid, busy, alu_op_a, alu_op_b, alu_opsel);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_basic();
    issue(1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0, 1);
    wait_idle();
    issue(1'b1, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    wait_idle();
    issue(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 1'b1, 1'b0, 1);
    wait_idle();
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b0, 1'b1, 1);
    wait_idle();
  endtask

  task automatic test_round_robin();
    logic [31:0] a0[2] = '{32'd10, 32'd30};
    logic [31:0] b0[2] = '{32'd1, 32'd3};
    logic [2:0]  s0[2] = '{3'b000, 3'b001};
    logic [31:0] a1[2] = '{32'd20, 32'd6};
    logic [31:0] b1[2] = '{32'd2, 32'd7};
    logic [2:0]  s1[2] = '{3'b000, 3'b010};
    int i0 = 0;
    int i1 = 0;
    logic got;
    do_reset();
    push(1'b0, 32'd10, 32'd1, 3'b000, 32'd11, 1'b0, 1'b0, 1);
    push(1'b1, 32'd20, 32'd2, 3'b000, 32'd22, 1'b0, 1'b0, 1);
    push(1'b0, 32'd30, 32'd3, 3'b001, 32'd27, 1'b0, 1'b0, 1);
    push(1'b1, 32'd6,  32'd7, 3'b010, 32'd42, 1'b0, 1'b0, 2);
    req0_valid = 1'b1; req0_op_a = a0[0]; req0_op_b = b0[0]; req0_opsel = s0[0];
    req1_valid = 1'b1; req1_op_a = a1[0]; req1_op_b = b1[0]; req1_opsel = s1[0];
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      #1;
      while (!req0_ready && !req1_ready && k < 100) begin
        step();
        k++;
      end
      checks++;
      if (!req0_ready && !req1_ready) begin
        errors++;
        $display("FAIL rr_timeout: got no grant for op %0d want a grant", i);
        break;
      end
      got = req1_ready;
      if (got !== i[0]) begin
        errors++;
        $display("FAIL grant_order: op %0d got req%0d want req%0d", i, got, i[0]);
      end
      step();
      if (!got) begin
        i0++;
        if (i0 < 2) begin
          req0_op_a = a0[i0]; req0_op_b = b0[i0]; req0_opsel = s0[i0];
        end else req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 2) begin
          req1_op_a = a1[i1]; req1_op_b = b1[i1]; req1_opsel = s1[i1];
        end else req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_multicycle();
    issue(1'b1, 32'd100, 32'd7, 3'b100, 32'd14, 1'b0, 1'b0, 4);
    wait_idle();
    issue(1'b1, 32'd100, 32'd7, 3'b101, 32'd2, 1'b0, 1'b0, 4);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'd4, 3'b011, 32'd2, 1'b0, 1'b0, 2);
    wait_idle();
    issue(1'b0, 32'h1234, 32'h10, 3'b010, 32'h12340, 1'b0, 1'b0, 2);
    wait_idle();
    issue(1'b0, 32'd9, 32'd0, 3'b100, 32'hFFFF_FFFF, 1'b0, 1'b0, 4);
    wait_idle();
    issue(1'b0, 32'd9, 32'd3, 3'b110, 32'd0, 1'b0, 1'b0, 1);
    wait_idle();
  endtask

  task automatic test_backpressure();
    int k = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 32'd3, 32'd4, 3'b000, 32'd7, 1'b0, 1'b0, 1);
    while (!rsp_valid && k < 20) begin
      step();
      k++;
    end
    push(1'b0, 32'd8, 32'd9, 3'b000, 32'd17, 1'b0, 1'b0, 1);
    req0_valid = 1'b1; req0_op_a = 32'd8; req0_op_b = 32'd9; req0_opsel = 3'b000;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_rsp: got valid=%b res=%h id=%b rdy0=%b busy=%b want 1 7 0 0 1",
                 rsp_valid, rsp_result, rsp_id, req0_ready, busy);
      end
      step();
    end
    rsp_ready = 1'b1;
    k = 0;
    #1;
    while (!req0_ready && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (!req0_ready) begin
      errors++;
      $display("FAIL held_req_timeout: got ready=0 want ready=1");
    end
    step();
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_exec();
    issue(1'b0, 32'd50, 32'd5, 3'b100, 32'd10, 1'b0, 1'b0, 4);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
      end
      step();
    end
    issue(1'b0, 32'd1, 32'd1, 3'b000, 32'd2, 1'b0, 1'b0, 1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op_a = '0; req0_op_b = '0; req0_opsel = '0;
    req1_op_a = '0; req1_op_b = '0; req1_opsel = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_multicycle();
    test_backpressure();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
